if_inst_queue: RTL and testbench

Parametrised instruction-fetch return queue that replaces the fixed two-slot blocked/cancel scheme of the fetch stage. It allocates one entry per accepted fetch request from pre-IF and fills entries in order as `data_ok` responses return. It presents completed instructions to ID with a valid/allowin handshake. On flush it discards every in-flight response, tracking them with a drop counter, so issue can resume immediately.

---
 rtl/if_inst_queue.sv | 164 ++++++++++++++++
 tb/tb_if_inst_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_inst_queue.sv
// Purpose: in-order fetch return queue; one entry per accepted fetch, filled by SRAM data_ok, drained to ID.
// Latency: data_ok (or exception alloc) on the head entry -> out_valid the next cycle; no same-cycle bypass.
// Backpressure: out_allowin stalls the head; can_issue drops when entries or outstanding SRAM slots run out.
//
// Ports:
//   clk, resetn                          clock, synchronous active-low reset
//   req_fire/req_pc/req_ex/req_ex_code   pre-IF request accepted this cycle (ex: no SRAM transaction issued)
//   can_issue                            pre-IF may fire this cycle (registered state only)
//   data_ok/rdata                        SRAM response, returns in request order
//   flush                                discard every entry; in-flight responses are counted for dropping
//   out_allowin/out_valid/out_*          head entry handshake and payload towards ID
//   outstanding                          responses still expected from SRAM (drops + pending entries)
module if_inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_fire,
    input  logic [31:0]              req_pc,
    input  logic                     req_ex,
    input  logic [14:0]              req_ex_code,
    output logic                     can_issue,
    input  logic                     data_ok,
    input  logic [31:0]              rdata,
    input  logic                     flush,
    input  logic                     out_allowin,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_ex,
    output logic [14:0]              out_ex_code,
    output logic [$clog2(DEPTH):0]   outstanding
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_pending;
    logic [DEPTH-1:0] ent_ex;
    logic [31:0]      ent_pc   [DEPTH];
    logic [31:0]      ent_inst [DEPTH];
    logic [14:0]      ent_code [DEPTH];

    ptr_t        head;
    ptr_t        tail;
    cnt_t        count;
    cnt_t        drop_cnt;
    logic [31:0] last_pc;

    cnt_t pend_cnt;
    ptr_t scan_idx;
    ptr_t fill_idx;
    logic fill_hit;
    logic drop_hit;
    logic fill_en;
    logic alloc;
    logic pop;
    logic not_empty;
    cnt_t drop_nxt;

    // Pending count and oldest pending entry, scanning forward from head.
    always_comb begin
        pend_cnt = '0;
        fill_hit = 1'b0;
        fill_idx = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + cnt_t'(ent_pending[i]);
            scan_idx = head + ptr_t'(i);
            if (!fill_hit && ent_valid[scan_idx] && ent_pending[scan_idx]) begin
                fill_hit = 1'b1;
                fill_idx = scan_idx;
            end
        end
    end

    // Responses owed to flushed requests are consumed first, keeping SRAM returns in order.
    assign drop_hit  = data_ok && (drop_cnt != '0);
    assign fill_en   = data_ok && !drop_hit && fill_hit;
    assign alloc     = req_fire && !flush;
    assign not_empty = (count != '0);

    assign out_valid   = not_empty && ent_valid[head] && !ent_pending[head] && !flush;
    assign pop         = out_valid && out_allowin;
    assign out_pc      = not_empty ? ent_pc[head]   : last_pc;
    assign out_inst    = not_empty ? ent_inst[head] : 32'h0;
    assign out_ex      = not_empty ? ent_ex[head]   : 1'b0;
    assign out_ex_code = not_empty ? ent_code[head] : 15'h0;

    // drop_cnt + pend_cnt never exceeds DEPTH, so the sum fits the count width.
    assign outstanding = drop_cnt + pend_cnt;
    assign can_issue   = (count < cnt_t'(DEPTH)) && (outstanding < cnt_t'(DEPTH));

    // On flush every pending entry (plus a request fired this cycle that went to SRAM)
    // becomes a response to drop; a data_ok in the same cycle retires one of them.
    always_comb begin
        drop_nxt = drop_cnt;
        if (flush) begin
            drop_nxt = drop_cnt + pend_cnt + cnt_t'(req_fire && !req_ex)
                     - cnt_t'(data_ok && (outstanding != '0));
        end else if (drop_hit) begin
            drop_nxt = drop_cnt - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ent_valid   <= '0;
            ent_pending <= '0;
            ent_ex      <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            drop_cnt    <= '0;
            last_pc     <= RESET_PC;
        end else begin
            drop_cnt <= drop_nxt;
            if (flush) begin
                ent_valid   <= '0;
                ent_pending <= '0;
                ent_ex      <= '0;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
            end else begin
                if (fill_en) begin
                    ent_pending[fill_idx] <= 1'b0;
                end
                if (pop) begin
                    ent_valid[head] <= 1'b0;
                    ent_ex[head]    <= 1'b0;
                    head            <= head + ptr_t'(1);
                    last_pc         <= ent_pc[head];
                end
                // A full queue never allocates, so tail cannot collide with the popped head.
                if (alloc) begin
                    ent_valid[tail]   <= 1'b1;
                    ent_pending[tail] <= !req_ex;
                    ent_ex[tail]      <= req_ex;
                    tail              <= tail + ptr_t'(1);
                end
                count <= count + cnt_t'(alloc) - cnt_t'(pop);
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind a valid entry.
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            if (fill_en) begin
                ent_inst[fill_idx] <= rdata;
            end
            if (alloc) begin
                ent_pc[tail]   <= req_pc;
                ent_inst[tail] <= 32'h0;
                ent_code[tail] <= req_ex_code;
            end
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
module tb_if_inst_queue;

    localparam logic [31:0] RST_PC = 32'h1C000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_fire;
    logic [31:0] req_pc;
    logic        req_ex;
    logic [14:0] req_ex_code;
    logic        can_issue;
    logic        data_ok;
    logic [31:0] rdata;
    logic        flush;
    logic        out_allowin;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ex;
    logic [14:0] out_ex_code;
    logic [2:0]  outstanding;

    if_inst_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn),
        .req_fire(req_fire), .req_pc(req_pc), .req_ex(req_ex), .req_ex_code(req_ex_code),
        .can_issue(can_issue),
        .data_ok(data_ok), .rdata(rdata), .flush(flush),
        .out_allowin(out_allowin), .out_valid(out_valid),
        .out_pc(out_pc), .out_inst(out_inst), .out_ex(out_ex), .out_ex_code(out_ex_code),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [14:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;
    int   max_out = 0;
    bit   track = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1 && out_allowin === 1'b1) begin
            pops++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got pc 0x%08h with nothing expected", out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_pc",   out_pc,                 e.pc);
                check("pop_inst", out_inst,               e.inst);
                check("pop_ex",   {31'h0, out_ex},        {31'h0, e.ex});
                check("pop_code", {17'h0, out_ex_code},   {17'h0, e.code});
            end
        end
        if (track && int'(outstanding) > max_out) max_out = int'(outstanding);
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_fire    = 1'b0;
        req_ex      = 1'b0;
        req_ex_code = 15'h0;
        data_ok     = 1'b0;
        flush       = 1'b0;
        #1;
    endtask

    task automatic fire(input logic [31:0] pc, input logic ex, input logic [14:0] code);
        exp_t e;
        req_fire    = 1'b1;
        req_pc      = pc;
        req_ex      = ex;
        req_ex_code = code;
        e.pc   = pc;
        e.inst = ex ? 32'h0 : ~pc;
        e.ex   = ex;
        e.code = code;
        if (!flush) exp_q.push_back(e);
    endtask

    task automatic resp(input logic [31:0] d);
        data_ok = 1'b1;
        rdata   = d;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        resetn = 1'b0; out_allowin = 1'b0;
        req_fire = 1'b0; req_pc = 32'h0; req_ex = 1'b0; req_ex_code = 15'h0;
        data_ok = 1'b0; rdata = 32'h0; flush = 1'b0;
        step(); step();
        resetn = 1'b1;
        #1;
        check("rst_out_valid",   {31'h0, out_valid},   32'h0);
        check("rst_can_issue",   {31'h0, can_issue},   32'h1);
        check("rst_outstanding", {29'h0, outstanding}, 32'h0);
        check("rst_out_pc",      out_pc,               RST_PC);
        check("rst_out_inst",    out_inst,             32'h0);
        check("rst_out_ex",      {31'h0, out_ex},      32'h0);
        check("rst_out_ex_code", {17'h0, out_ex_code}, 32'h0);

        // Stream: one response a cycle after each request, ID always accepting.
        out_allowin = 1'b1; track = 1'b1; pops_before = pops;
        fire(32'h1C000000, 1'b0, 15'h0); step();
        fire(32'h1C000004, 1'b0, 15'h0); resp(~32'h1C000000); step();
        check("stream_can_issue", {31'h0, can_issue}, 32'h1);
        fire(32'h1C000008, 1'b0, 15'h0); resp(~32'h1C000004); step();
        fire(32'h1C00000C, 1'b0, 15'h0); resp(~32'h1C000008); step();
        resp(~32'h1C00000C); step();
        drain("stream_drain", 10);
        track = 1'b0;
        check("stream_pops", pops - pops_before, 4);
        check("stream_max_outstanding_le2", {31'h0, max_out <= 2}, 32'h1);

        // Full / backpressure.
        out_allowin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fire(32'h1C000000 + 32'(4 * k), 1'b0, 15'h0);
            if (k > 0) resp(~(32'h1C000000 + 32'(4 * (k - 1))));
            step();
        end
        #1;
        check("full_can_issue", {31'h0, can_issue}, 32'h0);
        check("full_head_pc",   out_pc,             32'h1C000000);
        resp(~32'h1C00000C); step();
        #1;
        check("full_out_valid", {31'h0, out_valid}, 32'h1);
        check("full_head_hold", out_pc,             32'h1C000000);
        out_allowin = 1'b1;
        #1;
        check("full_no_pop_bypass", {31'h0, can_issue}, 32'h0);
        step();
        check("can_issue_after_pop", {31'h0, can_issue}, 32'h1);
        step(); step(); step();
        check("full_drained_valid", {31'h0, out_valid}, 32'h0);
        check("full_drained_queue", exp_q.size(), 0);
        check("empty_holds_last_pc", out_pc, 32'h1C00000C);

        // Flush with responses in flight.
        out_allowin = 1'b0;
        fire(32'h1C000020, 1'b0, 15'h0); step();
        fire(32'h1C000024, 1'b0, 15'h0); resp(~32'h1C000020); step();
        fire(32'h1C000028, 1'b0, 15'h0); step();
        check("pre_flush_valid", {31'h0, out_valid}, 32'h1);
        flush = 1'b1; exp_q.delete();
        #1;
        check("flush_masks_valid", {31'h0, out_valid}, 32'h0);
        step();
        check("flush_drop_cnt",   {29'h0, outstanding}, 32'h2);
        check("flush_count_zero", {31'h0, out_valid},   32'h0);
        check("flush_can_issue",  {31'h0, can_issue},   32'h1);
        out_allowin = 1'b1;
        fire(32'h1C000100, 1'b0, 15'h0); step();
        check("post_flush_outstanding", {29'h0, outstanding}, 32'h3);
        resp(32'hDEAD0001); step();
        resp(32'hDEAD0002); step();
        check("drops_exhausted",      {29'h0, outstanding}, 32'h1);
        check("drops_no_fill_valid",  {31'h0, out_valid},   32'h0);
        resp(~32'h1C000100); step();
        drain("flush_refill_drain", 10);

        // Flush and data_ok in the same cycle.
        out_allowin = 1'b0;
        fire(32'h1C000300, 1'b0, 15'h0); step();
        flush = 1'b1; exp_q.delete(); step();
        check("flush2_drop1", {29'h0, outstanding}, 32'h1);
        fire(32'h1C000304, 1'b0, 15'h0); step();
        fire(32'h1C000308, 1'b0, 15'h0); step();
        check("flush2_pre_outstanding", {29'h0, outstanding}, 32'h3);
        resp(32'hDEAD0003); flush = 1'b1; exp_q.delete();
        #1;
        check("flush2_out_valid", {31'h0, out_valid}, 32'h0);
        step();
        check("flush_data_ok_drop", {29'h0, outstanding}, 32'h2);
        resp(32'hDEAD0004); step();
        resp(32'hDEAD0005); step();
        check("flush2_drained", {29'h0, outstanding}, 32'h0);

        // Exception fetch behind a pending entry.
        out_allowin = 1'b1;
        fire(32'h1C000200, 1'b0, 15'h0); step();
        fire(32'h1C000204, 1'b1, 15'h0008); step();
        check("ex_waits_pending",   {31'h0, out_valid},   32'h0);
        check("ex_not_outstanding", {29'h0, outstanding}, 32'h1);
        step();
        check("ex_still_waiting", {31'h0, out_valid}, 32'h0);
        resp(~32'h1C000200); step();
        drain("ex_drain", 10);

        // Reset in the middle of activity.
        out_allowin = 1'b0;
        fire(32'h1C000400, 1'b0, 15'h0); step();
        flush = 1'b1; exp_q.delete(); step();
        fire(32'h1C000404, 1'b0, 15'h0); step();
        fire(32'h1C000408, 1'b0, 15'h0); step();
        fire(32'h1C00040C, 1'b0, 15'h0); step();
        check("midrst_pre_outstanding", {29'h0, outstanding}, 32'h4);
        check("midrst_pre_can_issue",   {31'h0, can_issue},   32'h0);
        resetn = 1'b0; exp_q.delete(); step();
        resetn = 1'b1;
        #1;
        check("midrst_out_valid",   {31'h0, out_valid},   32'h0);
        check("midrst_outstanding", {29'h0, outstanding}, 32'h0);
        check("midrst_can_issue",   {31'h0, can_issue},   32'h1);
        check("midrst_out_pc",      out_pc,               RST_PC);
        out_allowin = 1'b1;
        fire(32'h1C000500, 1'b0, 15'h0); step();
        resp(~32'h1C000500); step();
        drain("post_reset_drain", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
